// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Fills instruction memory from a framed byte stream before the core runs.
//   Frame: N[15:8], N[7:0], N*BYTES payload bytes (MSB byte of each word
//   first), then one checksum byte equal to the XOR of all payload bytes.
//   The core is held in reset until a complete image with a matching
//   checksum has been written.
//
// Ports
//   clock        system clock, rising edge
//   nreset       synchronous active-low reset
//   in_data      stream byte
//   in_valid     in_data valid this cycle
//   in_ready     byte accepted when in_valid && in_ready
//   mem_addr     instruction memory write address (holds last written)
//   mem_wenable  one-cycle write strobe
//   mem_wvalue   word to write (holds last written)
//   cpu_nreset   active-low core reset, released after a verified load
//   load_done    image loaded and verified (sticky)
//   load_error   framing or checksum failure (sticky)
//   words_loaded number of words written so far
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wenable,
    output logic [DATA_WIDTH-1:0] mem_wvalue,
    output logic                  cpu_nreset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    // Largest legal word count; the image may fill the whole memory.
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {HDR_HI, HDR_LO, PAYLOAD, CHECK, RUN, ERROR} state_t;

    state_t                state_q, state_d;
    logic [15:0]           n_q, n_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic [7:0]            csum_q, csum_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wval_q, wval_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;

    logic        xfer;
    logic [15:0] hdr_n;
    logic        last_byte;
    logic        last_word;

    assign xfer      = in_valid && in_ready;
    assign hdr_n     = {n_q[15:8], in_data};
    assign last_byte = (bcnt_q == BW'(BYTES - 1));
    // words_q still holds the pre-increment count while the final byte lands.
    assign last_word = ((33'(words_q) + 33'd1) == 33'(n_q));

    // State register
    always_ff @(posedge clock) begin
        if (!nreset) state_q <= HDR_HI;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR_HI:  if (xfer) state_d = HDR_LO;
            HDR_LO: begin
                if (xfer) begin
                    if (33'(hdr_n) > MAX_WORDS) state_d = ERROR;
                    else if (hdr_n == 16'd0)    state_d = CHECK;
                    else                        state_d = PAYLOAD;
                end
            end
            PAYLOAD: if (xfer && last_byte && last_word) state_d = CHECK;
            CHECK:   if (xfer) state_d = (in_data == csum_q) ? RUN : ERROR;
            default: ;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        in_ready   = nreset && (state_q == HDR_HI || state_q == HDR_LO ||
                                state_q == PAYLOAD || state_q == CHECK);
        cpu_nreset = (state_q == RUN);
        load_done  = (state_q == RUN);
        load_error = (state_q == ERROR);
    end

    // Datapath: header capture, word assembly, checksum, write port
    always_comb begin
        n_d     = n_q;
        bcnt_d  = bcnt_q;
        csum_d  = csum_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wen_d   = 1'b0;
        wval_d  = wval_q;
        words_d = words_q;
        if (xfer) begin
            case (state_q)
                HDR_HI: n_d[15:8] = in_data;
                HDR_LO: n_d[7:0]  = in_data;
                PAYLOAD: begin
                    word_d = (word_q << 8) | DATA_WIDTH'(in_data);
                    csum_d = csum_q ^ in_data;
                    if (last_byte) begin
                        bcnt_d  = '0;
                        wen_d   = 1'b1;
                        wval_d  = word_d;
                        addr_d  = words_q[ADDR_WIDTH-1:0];
                        words_d = words_q + 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            n_q     <= '0;
            bcnt_q  <= '0;
            csum_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wval_q  <= '0;
            words_q <= '0;
        end else begin
            n_q     <= n_d;
            bcnt_q  <= bcnt_d;
            csum_q  <= csum_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wval_q  <= wval_d;
            words_q <= words_d;
        end
    end

    assign mem_addr     = addr_q;
    assign mem_wenable  = wen_q;
    assign mem_wvalue   = wval_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    logic        clock = 1'b0;
    logic        nreset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  mem_addr;
    logic        mem_wenable;
    logic [15:0] mem_wvalue;
    logic        cpu_nreset;
    logic        load_done;
    logic        load_error;
    logic [8:0]  words_loaded;

    always #5 clock = ~clock;

    imem_boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clock        (clock),
        .nreset       (nreset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_addr     (mem_addr),
        .mem_wenable  (mem_wenable),
        .mem_wvalue   (mem_wvalue),
        .cpu_nreset   (cpu_nreset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int unsigned addr;
        logic [15:0] data;
        int          stamp;
    } wr_t;

    wr_t         sb[$];
    logic [15:0] pl[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every strobe must match the oldest expected write, one cycle after its
    // final byte handshake.
    always @(negedge clock) begin
        if (mem_wenable === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {31'b0, mem_wenable}, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", {24'b0, mem_addr}, e.addr);
                chk("wr_data", {16'b0, mem_wvalue}, {16'b0, e.data});
                chk("wr_cycle", cyc, e.stamp + 1);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one byte; returns right after the handshake edge with the
    // cycle stamp of that edge.
    task automatic send_byte(input logic [7:0] b, output int stamp);
        int k;
        @(negedge clock);
        in_data  = b;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk("in_ready_before_byte", {31'b0, in_ready}, 32'd1);
        stamp = cyc;
        @(posedge clock);
    endtask

    task automatic idle_gap(input int gap);
        if (gap > 0) begin
            @(negedge clock);
            in_valid = 1'b0;
            repeat (gap - 1) @(negedge clock);
        end
    endtask

    task automatic run_frame(input int n, input int gap, input logic [7:0] cx);
        logic [15:0] nn;
        logic [15:0] w;
        logic [7:0]  cs;
        int          st;
        wr_t         e;
        nn = n[15:0];
        cs = 8'h00;
        send_byte(nn[15:8], st); idle_gap(gap);
        send_byte(nn[7:0], st);  idle_gap(gap);
        for (int i = 0; i < n; i++) begin
            w = pl[i];
            send_byte(w[15:8], st); idle_gap(gap);
            send_byte(w[7:0], st);
            e.addr = i; e.data = w; e.stamp = st;
            sb.push_back(e);
            idle_gap(gap);
            cs = cs ^ w[15:8] ^ w[7:0];
        end
        send_byte(cs ^ cx, st);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic check_final(input logic done, input logic err, input int words, input logic rdy);
        chk("load_done",    {31'b0, load_done},    {31'b0, done});
        chk("load_error",   {31'b0, load_error},   {31'b0, err});
        chk("cpu_nreset",   {31'b0, cpu_nreset},   {31'b0, done});
        chk("words_loaded", {23'b0, words_loaded}, words);
        chk("in_ready",     {31'b0, in_ready},     {31'b0, rdy});
        chk("writes_drained", sb.size(), 32'd0);
    endtask

    // Keep offering bytes in a terminal state; nothing may change.
    task automatic poke_terminal(input int words);
        repeat (3) begin
            @(negedge clock);
            in_data  = 8'h5A;
            in_valid = 1'b1;
            chk("terminal_ready", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clock);
        in_valid = 1'b0;
        chk("terminal_words", {23'b0, words_loaded}, words);
    endtask

    task automatic do_reset();
        @(negedge clock);
        nreset   = 1'b0;
        in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("rst_mem_addr",   {24'b0, mem_addr},     32'd0);
        chk("rst_wenable",    {31'b0, mem_wenable},  32'd0);
        chk("rst_wvalue",     {16'b0, mem_wvalue},   32'd0);
        chk("rst_cpu_nreset", {31'b0, cpu_nreset},   32'd0);
        chk("rst_done",       {31'b0, load_done},    32'd0);
        chk("rst_error",      {31'b0, load_error},   32'd0);
        chk("rst_words",      {23'b0, words_loaded}, 32'd0);
        chk("rst_in_ready",   {31'b0, in_ready},     32'd0);
        sb.delete();
        nreset = 1'b1;
    endtask

    initial begin
        int st;
        nreset   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clock);
        do_reset();

        // Two-word frame, in_valid held high
        pl.delete(); pl.push_back(16'h1234); pl.push_back(16'hABCD);
        run_frame(2, 0, 8'h00);
        check_final(1'b1, 1'b0, 2, 1'b0);
        chk("hold_addr",   {24'b0, mem_addr},   32'd1);
        chk("hold_wvalue", {16'b0, mem_wvalue}, 32'hABCD);
        poke_terminal(2);

        // Same frame, checksum off by one
        do_reset();
        run_frame(2, 0, 8'h01);
        check_final(1'b0, 1'b1, 2, 1'b0);
        poke_terminal(2);

        // Empty image, good and bad checksum
        do_reset();
        pl.delete();
        run_frame(0, 0, 8'h00);
        check_final(1'b1, 1'b0, 0, 1'b0);
        do_reset();
        run_frame(0, 0, 8'h05);
        check_final(1'b0, 1'b1, 0, 1'b0);

        // Oversized header N=257
        do_reset();
        send_byte(8'h01, st);
        send_byte(8'h01, st);
        @(negedge clock);
        in_valid = 1'b0;
        check_final(1'b0, 1'b1, 0, 1'b0);
        poke_terminal(0);

        // Full memory image N=256
        do_reset();
        pl.delete();
        for (int i = 0; i < 256; i++) pl.push_back(16'($urandom));
        run_frame(256, 0, 8'h00);
        check_final(1'b1, 1'b0, 256, 1'b0);
        chk("full_last_addr", {24'b0, mem_addr}, 32'hFF);
        chk("full_last_data", {16'b0, mem_wvalue}, {16'b0, pl[255]});

        // Two-word frame with 3-cycle gaps between bytes
        do_reset();
        pl.delete(); pl.push_back(16'h1234); pl.push_back(16'hABCD);
        run_frame(2, 3, 8'h00);
        check_final(1'b1, 1'b0, 2, 1'b0);
        chk("gap_addr",   {24'b0, mem_addr},   32'd1);
        chk("gap_wvalue", {16'b0, mem_wvalue}, 32'hABCD);

        // Reset in the middle of a frame, then a clean frame
        do_reset();
        send_byte(8'h00, st);
        send_byte(8'h02, st);
        send_byte(8'h12, st);
        do_reset();
        run_frame(2, 0, 8'h00);
        check_final(1'b1, 1'b0, 2, 1'b0);
        chk("after_rst_addr",   {24'b0, mem_addr},   32'd1);
        chk("after_rst_wvalue", {16'b0, mem_wvalue}, 32'hABCD);

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream of the CPU core; fills instruction memory from a byte stream before execution starts.
- Receives a framed program image on a valid/ready byte interface and assembles bytes into instruction words.
- Writes each word into instruction memory at consecutive addresses and verifies an XOR checksum.
- Holds the core in reset via cpu_nreset until a complete, checksum-valid image is loaded.

Parameters:
ADDR_WIDTH, 8, instruction memory address width (matches core imem address width)
DATA_WIDTH, 16, instruction word width; must be a multiple of 8
BYTES (local), DATA_WIDTH/8, bytes per instruction word

Ports:
clock  input  1  system clock, all state updates on rising edge
nreset  input  1  synchronous active-low reset
in_data  input  8  stream byte
in_valid  input  1  in_data valid this cycle
in_ready  output  1  loader accepts a byte this cycle; transfer when in_valid && in_ready
mem_addr  output  ADDR_WIDTH  instruction memory write address
mem_wenable  output  1  one-cycle write strobe
mem_wvalue  output  DATA_WIDTH  instruction word to write
cpu_nreset  output  1  active-low reset to core; 1 only after successful load
load_done  output  1  image loaded and verified (sticky)
load_error  output  1  framing/checksum failure (sticky)
words_loaded  output  ADDR_WIDTH+1  count of words written

Behaviour:
- Reset (nreset=0 at a clock edge): state=HDR_HI; mem_addr=0, mem_wenable=0, mem_wvalue=0, cpu_nreset=0, load_done=0, load_error=0, words_loaded=0, byte counter=0, checksum=0, word count N=0. in_ready=0 during the reset cycle.
- Frame format: N[15:8], N[7:0], then N*BYTES payload bytes (per word MSB byte first), then 1 checksum byte = XOR of all payload bytes (header excluded; 0x00 when N=0).
- in_ready=1 in HDR_HI, HDR_LO, PAYLOAD, CHECK; 0 in RUN and ERROR. State advances only on handshake; in_valid gaps stall with no state change.
- HDR_HI: accept byte -> N[15:8]; go to HDR_LO.
- HDR_LO: accept byte -> N[7:0]. If full N > 2^ADDR_WIDTH -> ERROR. If N==0 -> CHECK. Else -> PAYLOAD.
- PAYLOAD: shift each byte into the word assembler (word = {word[DATA_WIDTH-9:0], byte}). XOR the byte into checksum. On the BYTES-th byte of a word:
  - next cycle mem_wenable=1 for exactly one cycle, mem_wvalue=assembled word, mem_addr=words_loaded (pre-increment value);
  - words_loaded increments in that same cycle.
  - After the last byte of word N-1, go to CHECK.
- Write latency: exactly 1 cycle after the final byte handshake of a word. Back-to-back words may produce strobes on consecutive-word boundaries only (never two strobes in adjacent cycles when BYTES>=2).
- CHECK: accept byte. If equal to checksum -> RUN, else -> ERROR.
- RUN: load_done=1 and cpu_nreset=1, both registered, first asserted the cycle after the checksum handshake. Terminal until nreset.
- ERROR: load_error=1, cpu_nreset held 0, no further writes. Terminal until nreset.
- mem_addr holds last written address while mem_wenable=0; mem_wvalue holds last word.
- N == 2^ADDR_WIDTH is legal: last write at address 2^ADDR_WIDTH-1; words_loaded reaches 2^ADDR_WIDTH (hence the extra bit).
- Reset mid-operation: all state and outputs return to reset values the next edge. A pending write strobe is cancelled. Memory contents are not cleared.
- load_done and load_error are never both 1.

Test Plan:
- Bytes 00 02 12 34 AB CD 40, in_valid held 1 -> writes addr0=0x1234, addr1=0xABCD, each one cycle after its 2nd byte; cpu_nreset=1, load_done=1 one cycle after byte 0x40; words_loaded=2; in_ready=0 thereafter.
- Same frame with checksum 0x41 -> both writes occur; load_error=1, cpu_nreset stays 0, in_ready=0; further in_valid ignored.
- Bytes 00 00 00 -> no mem_wenable pulse; load_done=1, words_loaded=0. Bytes 00 00 05 -> load_error=1.
- Header 01 01 (N=257, ADDR_WIDTH=8) -> load_error=1 the cycle after the second byte, in_ready=0, no writes. Header 01 00 with 256 words and correct checksum -> last write addr 0xFF, words_loaded=256, load_done=1.
- Frame from scenario 1 with in_valid deasserted for 3 cycles between every byte -> identical writes and final outputs; no strobe during gaps.
- nreset pulsed low after byte 0x12 of scenario 1 -> all outputs at reset values, no write. A full clean frame sent afterwards -> same result as scenario 1.
